// File: rtl/camera_heading_ctrl.sv
// Debounced left/right buttons -> frame-synchronous camera heading (0..359); 1-cycle apply latency after new_frame_in, no backpressure.
// Optional HEADING_RECENTER_EN: both buttons held REPEAT_DELAY_FRAMES frames snaps the heading back to HOME_ANGLE.
module camera_heading_ctrl #(
   parameter int DEBOUNCE_CYCLES      = 371250,
   parameter int STEP_DEG             = 3,
   parameter int REPEAT_DELAY_FRAMES  = 20,
   parameter int REPEAT_PERIOD_FRAMES = 2,
   parameter int HOME_ANGLE           = 90
) (
   input  logic        pixel_clk_in,
   input  logic        rst_n_in,
   input  logic        new_frame_in,
   input  logic        btn_left_in,
   input  logic        btn_right_in,
   output logic [15:0] angle_out,
   output logic [1:0]  step_dir_out,
   output logic        stepped_out
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int FMAX = (REPEAT_DELAY_FRAMES > REPEAT_PERIOD_FRAMES) ? REPEAT_DELAY_FRAMES
                                                                      : REPEAT_PERIOD_FRAMES;
   localparam int FW   = $clog2(FMAX + 2);

   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [FW-1:0] DELAY_C  = FW'(REPEAT_DELAY_FRAMES);
   localparam logic [FW-1:0] PERIOD_C = FW'(REPEAT_PERIOD_FRAMES);
   localparam logic [FW-1:0] FSAT     = '1;
   localparam logic [9:0]    STEP_C   = 10'(STEP_DEG);
   localparam logic [9:0]    HOME_C   = 10'(HOME_ANGLE);

   typedef enum logic [1:0] {S_IDLE, S_FIRST, S_HOLD, S_REPEAT} btn_state_e;

   // Reset asserts asynchronously but releases on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) rst_sync_q <= '0;
      else           rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   logic [1:0] btn_raw, deb, set_pend, pend_q, pend_d;
   logic       lock, rc_pend;

   assign btn_raw = {btn_right_in, btn_left_in};

   for (genvar i = 0; i < 2; i++) begin : g_btn
      logic [1:0]    sync_q;
      logic          deb_q, deb_d, set_c;
      logic [DW-1:0] dcnt_q, dcnt_d;
      logic [FW-1:0] fcnt_q, fcnt_d;
      btn_state_e    st_q, st_d;

      always_comb begin
         deb_d  = deb_q;
         dcnt_d = '0;
         if (sync_q[1] != deb_q) begin
            if (dcnt_q == DEB_LAST) deb_d  = ~deb_q;
            else                    dcnt_d = dcnt_q + 1'b1;
         end
      end

      always_comb begin
         st_d   = st_q;
         fcnt_d = fcnt_q;
         set_c  = 1'b0;
         if (new_frame_in && (fcnt_q != FSAT)) fcnt_d = fcnt_q + 1'b1;
         case (st_q)
            S_IDLE:   if (deb_q) st_d = S_FIRST;
            S_FIRST:  begin set_c = 1'b1; fcnt_d = '0; st_d = S_HOLD; end
            S_HOLD:   if (fcnt_q >= DELAY_C) begin
                         set_c = 1'b1; fcnt_d = '0; st_d = S_REPEAT;
                      end
            S_REPEAT: if (fcnt_q >= PERIOD_C) begin set_c = 1'b1; fcnt_d = '0; end
            default:  st_d = S_IDLE;
         endcase
         // Release returns to IDLE but leaves any already-raised request in place.
         if (lock) begin
            st_d  = S_IDLE;
            set_c = 1'b0;
         end else if (!deb_q) begin
            st_d = S_IDLE;
         end
      end

      always_ff @(posedge pixel_clk_in or negedge rst_n) begin
         if (!rst_n) begin
            sync_q <= '0;
            deb_q  <= 1'b0;
            dcnt_q <= '0;
            st_q   <= S_IDLE;
            fcnt_q <= '0;
         end else begin
            sync_q <= {sync_q[0], btn_raw[i]};
            deb_q  <= deb_d;
            dcnt_q <= dcnt_d;
            st_q   <= st_d;
            fcnt_q <= fcnt_d;
         end
      end

      assign deb[i]      = deb_q;
      assign set_pend[i] = set_c;
   end

`ifdef HEADING_RECENTER_EN
   logic [FW-1:0] bcnt_q, bcnt_d;
   logic          lock_q, lock_d, rc_q, rc_d;

   always_comb begin
      bcnt_d = '0;
      lock_d = lock_q;
      rc_d   = rc_q & ~new_frame_in;
      if (lock_q) begin
         if (deb == 2'b00) lock_d = 1'b0;
      end else if (deb == 2'b11) begin
         bcnt_d = bcnt_q;
         if (new_frame_in && (bcnt_q != FSAT)) bcnt_d = bcnt_q + 1'b1;
         if (bcnt_q >= DELAY_C) begin
            rc_d   = 1'b1;
            lock_d = 1'b1;
            bcnt_d = '0;
         end
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_q <= '0;
         lock_q <= 1'b0;
         rc_q   <= 1'b0;
      end else begin
         bcnt_q <= bcnt_d;
         lock_q <= lock_d;
         rc_q   <= rc_d;
      end
   end

   assign lock    = lock_q;
   assign rc_pend = rc_q;
`else
   assign lock    = 1'b0;
   assign rc_pend = 1'b0;
`endif

   // A request raised on the frame-pulse cycle survives into the next frame.
   assign pend_d = (pend_q & {2{~new_frame_in}}) | set_pend;

   logic [9:0] angle_q, angle_d, left_sum;
   logic [1:0] dir_q, dir_d;
   logic       stepped_q, stepped_d;

   assign left_sum = angle_q + STEP_C;

   always_comb begin
      angle_d   = angle_q;
      dir_d     = dir_q;
      stepped_d = 1'b0;
      if (new_frame_in) begin
         if (rc_pend) begin
            angle_d   = HOME_C;
            dir_d     = 2'b00;
            stepped_d = 1'b1;
         end else begin
            case (pend_q)
               2'b01: begin
                  angle_d   = (left_sum >= 10'd360) ? left_sum - 10'd360 : left_sum;
                  dir_d     = 2'b01;
                  stepped_d = 1'b1;
               end
               2'b10: begin
                  angle_d   = (angle_q < STEP_C) ? angle_q + 10'd360 - STEP_C : angle_q - STEP_C;
                  dir_d     = 2'b10;
                  stepped_d = 1'b1;
               end
               2'b11:   dir_d = 2'b00;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n) begin
      if (!rst_n) begin
         pend_q    <= '0;
         angle_q   <= HOME_C;
         dir_q     <= 2'b00;
         stepped_q <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         angle_q   <= angle_d;
         dir_q     <= dir_d;
         stepped_q <= stepped_d;
      end
   end

   assign angle_out    = {6'b0, angle_q};
   assign step_dir_out = dir_q;
   assign stepped_out  = stepped_q;

endmodule

// File: tb/tb_camera_heading_ctrl.sv
// Directed bench for camera_heading_ctrl; a second instance homed at 1 degree exercises the 1<->358 wrap.
module tb_camera_heading_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, nf, bl, br, bl2, br2;
   logic [15:0] ang, ang2;
   logic [1:0]  dir, dir2;
   logic        stp, stp2;
   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;

   always #5 clk = ~clk;

   camera_heading_ctrl #(.DEBOUNCE_CYCLES(16)) u_dut (
      .pixel_clk_in(clk), .rst_n_in(rst_n), .new_frame_in(nf),
      .btn_left_in(bl), .btn_right_in(br),
      .angle_out(ang), .step_dir_out(dir), .stepped_out(stp));

   camera_heading_ctrl #(.DEBOUNCE_CYCLES(16), .HOME_ANGLE(1)) u_dut2 (
      .pixel_clk_in(clk), .rst_n_in(rst_n), .new_frame_in(nf),
      .btn_left_in(bl2), .btn_right_in(br2),
      .angle_out(ang2), .step_dir_out(dir2), .stepped_out(stp2));

   always @(posedge clk) if (stp === 1'b1) pulses++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic do_frame();
      nf = 1'b1;
      tick();
      nf = 1'b0;
   endtask

   task automatic gap_frame();
      wait_cycles(40);
      do_frame();
   endtask

   task automatic tap(input bit second, input bit right);
      if (second) begin
         if (right) br2 = 1'b1; else bl2 = 1'b1;
      end else begin
         if (right) br = 1'b1; else bl = 1'b1;
      end
      wait_cycles(30);
      do_frame();
      {bl, br, bl2, br2} = 4'b0000;
      wait_cycles(30);
   endtask

   task automatic test_reset();
      int p0;
      rst_n = 1'b0; nf = 1'b0; {bl, br, bl2, br2} = 4'b0000;
      wait_cycles(3);
      checks++; if (ang !== 16'd90) begin errors++; $display("FAIL reset_angle got %0d want 90", ang); end
      checks++; if (dir !== 2'b00) begin errors++; $display("FAIL reset_dir got %b want 00", dir); end
      checks++; if (stp !== 1'b0) begin errors++; $display("FAIL reset_stepped got %b want 0", stp); end
      checks++; if (ang2 !== 16'd1) begin errors++; $display("FAIL reset_angle2 got %0d want 1", ang2); end
      rst_n = 1'b1;
      wait_cycles(5);
      p0 = pulses;
      repeat (10) gap_frame();
      checks++; if (ang !== 16'd90) begin errors++; $display("FAIL idle_angle got %0d want 90", ang); end
      checks++; if (pulses !== p0) begin errors++; $display("FAIL idle_pulses got %0d want %0d", pulses, p0); end
   endtask

   task automatic test_debounce();
      int p0;
      p0 = pulses;
      for (int i = 0; i < 180; i++) begin
         bl = ~bl;
         wait_cycles($urandom_range(1, 10));
      end
      bl = 1'b1;
      wait_cycles(30);
      checks++; if (ang !== 16'd90) begin errors++; $display("FAIL dbnc_preframe got %0d want 90", ang); end
      do_frame();
      checks++; if (ang !== 16'd93) begin errors++; $display("FAIL dbnc_angle got %0d want 93", ang); end
      checks++; if (dir !== 2'b01) begin errors++; $display("FAIL dbnc_dir got %b want 01", dir); end
      checks++; if (stp !== 1'b1) begin errors++; $display("FAIL dbnc_stepped got %b want 1", stp); end
      tick();
      checks++; if (stp !== 1'b0) begin errors++; $display("FAIL dbnc_stepped_end got %b want 0", stp); end
      repeat (4) gap_frame();
      checks++; if (ang !== 16'd93) begin errors++; $display("FAIL dbnc_held got %0d want 93", ang); end
      checks++; if (pulses !== p0 + 1) begin errors++; $display("FAIL dbnc_pulses got %0d want %0d", pulses, p0 + 1); end
      bl = 1'b0;
      wait_cycles(30);
   endtask

   task automatic test_hold_repeat();
      int exp_a;
      exp_a = 93;
      br = 1'b1;
      wait_cycles(30);
      for (int f = 1; f <= 30; f++) begin
         gap_frame();
         if (f == 1 || (f >= 21 && (f % 2) == 1)) exp_a -= 3;
         checks++; if (ang !== 16'(exp_a)) begin errors++; $display("FAIL hold_frame%0d got %0d want %0d", f, ang, exp_a); end
      end
      br = 1'b0;
      wait_cycles(30);
      do_frame();
      checks++; if (ang !== 16'd72) begin errors++; $display("FAIL sticky_angle got %0d want 72", ang); end
      checks++; if (dir !== 2'b10) begin errors++; $display("FAIL sticky_dir got %b want 10", dir); end
   endtask

   task automatic test_wrap();
      repeat (24) tap(1'b0, 1'b1);
      checks++; if (ang !== 16'd0) begin errors++; $display("FAIL wrap_zero got %0d want 0", ang); end
      tap(1'b0, 1'b1);
      checks++; if (ang !== 16'd357) begin errors++; $display("FAIL wrap_0_right got %0d want 357", ang); end
      checks++; if (dir !== 2'b10) begin errors++; $display("FAIL wrap_0_right_dir got %b want 10", dir); end
      tap(1'b0, 1'b0);
      checks++; if (ang !== 16'd0) begin errors++; $display("FAIL wrap_357_left got %0d want 0", ang); end
      checks++; if (dir !== 2'b01) begin errors++; $display("FAIL wrap_357_left_dir got %b want 01", dir); end
      checks++; if (ang2 !== 16'd1) begin errors++; $display("FAIL wrap2_idle got %0d want 1", ang2); end
      tap(1'b1, 1'b1);
      checks++; if (ang2 !== 16'd358) begin errors++; $display("FAIL wrap2_1_right got %0d want 358", ang2); end
      checks++; if (dir2 !== 2'b10) begin errors++; $display("FAIL wrap2_1_right_dir got %b want 10", dir2); end
      tap(1'b1, 1'b0);
      checks++; if (ang2 !== 16'd1) begin errors++; $display("FAIL wrap2_358_left got %0d want 1", ang2); end
      checks++; if (dir2 !== 2'b01) begin errors++; $display("FAIL wrap2_358_left_dir got %b want 01", dir2); end
   endtask

   task automatic test_cancel();
      int p0, exp_a, exp_p;
      p0 = pulses;
      bl = 1'b1; br = 1'b1;
      wait_cycles(30);
      do_frame();
      checks++; if (ang !== 16'd0) begin errors++; $display("FAIL cancel_angle got %0d want 0", ang); end
      checks++; if (stp !== 1'b0) begin errors++; $display("FAIL cancel_stepped got %b want 0", stp); end
      checks++; if (dir !== 2'b00) begin errors++; $display("FAIL cancel_dir got %b want 00", dir); end
      repeat (25) gap_frame();
`ifdef HEADING_RECENTER_EN
      exp_a = 90; exp_p = p0 + 1;
`else
      exp_a = 0;  exp_p = p0;
`endif
      checks++; if (ang !== 16'(exp_a)) begin errors++; $display("FAIL both_held_angle got %0d want %0d", ang, exp_a); end
      checks++; if (pulses !== exp_p) begin errors++; $display("FAIL both_held_pulses got %0d want %0d", pulses, exp_p); end
      bl = 1'b0; br = 1'b0;
      wait_cycles(30);
      do_frame();
      checks++; if (ang !== 16'(exp_a)) begin errors++; $display("FAIL both_release_angle got %0d want %0d", ang, exp_a); end
   endtask

   task automatic test_reset_mid();
      int exp_a;
`ifdef HEADING_RECENTER_EN
      exp_a = 84;
`else
      exp_a = 354;
`endif
      br = 1'b1;
      wait_cycles(30);
      repeat (22) gap_frame();
      checks++; if (ang !== 16'(exp_a)) begin errors++; $display("FAIL mid_repeat_angle got %0d want %0d", ang, exp_a); end
      wait_cycles(7);
      #2 rst_n = 1'b0;
      #1;
      checks++; if (ang !== 16'd90) begin errors++; $display("FAIL async_reset_angle got %0d want 90", ang); end
      checks++; if (dir !== 2'b00) begin errors++; $display("FAIL async_reset_dir got %b want 00", dir); end
      checks++; if (ang2 !== 16'd1) begin errors++; $display("FAIL async_reset_angle2 got %0d want 1", ang2); end
      wait_cycles(3);
      rst_n = 1'b1;
      do_frame();
      checks++; if (ang !== 16'd90) begin errors++; $display("FAIL post_reset_nostep got %0d want 90", ang); end
      checks++; if (stp !== 1'b0) begin errors++; $display("FAIL post_reset_stepped got %b want 0", stp); end
      wait_cycles(30);
      do_frame();
      checks++; if (ang !== 16'd87) begin errors++; $display("FAIL post_reset_step got %0d want 87", ang); end
      checks++; if (dir !== 2'b10) begin errors++; $display("FAIL post_reset_dir got %b want 10", dir); end
      checks++; if (stp !== 1'b1) begin errors++; $display("FAIL post_reset_pulse got %b want 1", stp); end
      br = 1'b0;
      wait_cycles(30);
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_hold_repeat();
      test_wrap();
      test_cancel();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
